// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - shared defaults and enums for the data memory arbiter
//
// Holds the default memory geometry, the lock burst limit, the arbiter state
// encoding and the owner encoding used by data_mem_arbiter and arb_rr_pick.
package data_mem_arb_pkg;

  localparam int ADDR_W_DEF   = 4;
  localparam int DATA_W_DEF   = 16;
  localparam int LOCK_MAX_DEF = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCK_B = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - two-way round-robin pick
//
// Ports:
//   req_a, req_b  requests from port A and port B
//   last_owner    port granted most recently
//   owner         selected port (meaningful only when valid is high)
//   valid         at least one request present
module arb_rr_pick
  import data_mem_arb_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  owner_e last_owner,
  output owner_e owner,
  output logic   valid
);

  always_comb begin
    valid = req_a | req_b;
    if (req_a && req_b) begin
      // Conflict: the port that did not win last time goes first.
      owner = (last_owner == OWN_A) ? OWN_B : OWN_A;
    end else if (req_a) begin
      owner = OWN_A;
    end else begin
      owner = OWN_B;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin arbiter in front of a data memory
//
// Optional feature macro: ARB_LOCK_EN (adds b_lock and the LOCK_B burst state).
//
// Ports:
//   Clk, Rst                    clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A (CPU) request, held until a_gnt
//   a_gnt/a_rvalid/a_rdata      port A grant, read-valid pulse, read data
//   b_*                         port B (loader/DMA), same meaning as port A
//   b_lock                      (ARB_LOCK_EN only) B asks to keep ownership
//   mem_we/mem_addr/mem_wdata   memory write strobe, address, write data
//   mem_rdata                   combinational memory read data
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
`ifdef ARB_LOCK_EN
  input  logic              b_lock,
`endif
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (LOCK_MAX < 1) begin : g_lock_max_check
    $error("LOCK_MAX must be at least 1");
  end

  owner_e            last_owner_q;
  owner_e            pick_owner;
  logic              pick_valid;
  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

`ifdef ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
`endif

  arb_rr_pick u_pick (
    .req_a      (a_req),
    .req_b      (b_req),
    .last_owner (last_owner_q),
    .owner      (pick_owner),
    .valid      (pick_valid)
  );

  // Grants and lock next-state. Rst forces every grant low so no write or
  // read can be accepted in a reset cycle.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
`ifdef ARB_LOCK_EN
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
`endif
    if (!Rst) begin
`ifdef ARB_LOCK_EN
      if (state_q == LOCK_B) begin
        b_gnt = b_req;
        if (b_req) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
        if (!b_req || !b_lock || (lock_cnt_d >= CNT_W'(LOCK_MAX))) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end
      end else begin
        a_gnt = pick_valid && (pick_owner == OWN_A);
        b_gnt = pick_valid && (pick_owner == OWN_B);
        // The entry grant is the first transaction of the locked burst.
        if (b_gnt && b_lock && (LOCK_MAX > 1)) begin
          state_d    = LOCK_B;
          lock_cnt_d = CNT_W'(1);
        end
      end
`else
      a_gnt = pick_valid && (pick_owner == OWN_A);
      b_gnt = pick_valid && (pick_owner == OWN_B);
`endif
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (a_gnt) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (b_gnt) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      // OWN_B as last owner makes A win the first conflict.
      last_owner_q <= OWN_B;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
`ifdef ARB_LOCK_EN
      state_q      <= ARB;
      lock_cnt_q   <= '0;
`endif
    end else begin
      if (a_gnt) begin
        last_owner_q <= OWN_A;
      end else if (b_gnt) begin
        last_owner_q <= OWN_B;
      end
      a_rvalid_q <= a_gnt && !a_we;
      b_rvalid_q <= b_gnt && !b_we;
      if (a_gnt && !a_we) begin
        a_rdata_q <= mem_rdata;
      end
      if (b_gnt && !b_we) begin
        b_rdata_q <= mem_rdata;
      end
`ifdef ARB_LOCK_EN
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  // Outputs read as idle for the whole reset cycle, including a read
  // response that would otherwise land in it.
  assign a_rvalid = a_rvalid_q & ~Rst;
  assign b_rvalid = b_rvalid_q & ~Rst;
  assign a_rdata  = Rst ? '0 : a_rdata_q;
  assign b_rdata  = Rst ? '0 : b_rdata_q;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have parameter LOCK_MAX, default 4, maximum back-to-back locked transactions for port B.
REQ-004 Port Clk  in  1  the single clock; all state updates on rising edge.
REQ-005 Port Rst  in  1  reset, synchronous, active-high.
REQ-006 Ports a_req/a_we  in  1 each  port A (CPU) request / write-enable.
REQ-007 Ports a_addr  in  ADDR_W, a_wdata  in  DATA_W  port A address and write data.
REQ-008 Ports a_gnt  out  1, a_rvalid  out  1, a_rdata  out  DATA_W  port A grant, read-valid pulse, read data.
REQ-009 Ports b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  port B (loader/DMA), same widths and meaning as port A.
REQ-010 Port b_lock  in  1  present only with ARB_LOCK_EN; B requests to keep ownership.
REQ-011 Ports mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_rdata  in  DATA_W  drive the 16x16 data memory (write on Clk edge, combinational read).

Function
REQ-012 SHALL accept at most one transaction per cycle; a transaction is accepted in the cycle its gnt is high.
REQ-013 gnt SHALL be combinational from req, priority pointer and state; at most one gnt high per cycle.
REQ-014 Requesters hold req/we/addr/wdata stable until gnt; arbiter SHALL NOT grant a port whose req is low.
REQ-015 Arbitration: round-robin; the port not granted most recently wins a conflict; a sole requester wins immediately.
REQ-016 Priority pointer SHALL update only on an accepted transaction.
REQ-017 mem_addr/mem_wdata SHALL mux the granted port's fields; mem_we = granted port's we; with no grant mem_we = 0, mem_addr/mem_wdata = 0.
REQ-018 Accepted read: xx_rdata SHALL register mem_rdata at the accepting edge; xx_rvalid high for exactly the next cycle (latency 1).
REQ-019 Accepted write: no rvalid; memory updated at the accepting edge; a read of the same address in the next cycle SHALL return the new data.
REQ-020 xx_rdata SHALL hold its last value when rvalid is low.
REQ-021 States: ARB (normal round-robin) and LOCK_B (B owns memory); without ARB_LOCK_EN only ARB exists.
REQ-022 Back-to-back: same port may be granted consecutive cycles when the other port is idle.

Reset
REQ-023 While Rst high: all gnt = 0, mem_we = 0, rvalid = 0, rdata = 0, state = ARB, lock count = 0, pointer set so A wins the first conflict.
REQ-024 Rst asserted mid-operation SHALL suppress any pending rvalid and any write in that cycle.
REQ-025 First conflict after Rst deassertion SHALL grant A.

Configuration
REQ-026 Macro ARB_LOCK_EN: when defined, b_lock exists; B granted with b_lock = 1 moves ARB -> LOCK_B.
REQ-027 In LOCK_B: only B may be granted; each accepted B transaction increments lock count; exit to ARB when b_lock = 0, b_req = 0, or count reaches LOCK_MAX; pointer then favours A.
REQ-028 Without ARB_LOCK_EN: no b_lock port, no LOCK_B state, no lock counter; pure round-robin.

Structure
REQ-029 Package data_mem_arb_pkg SHALL hold ADDR_W/DATA_W/LOCK_MAX defaults, state enum (ARB, LOCK_B) and owner enum (OWN_A, OWN_B).
REQ-030 Two-way round-robin pick SHALL be sub-module arb_rr_pick (inputs req_a, req_b, last_owner; output owner, valid).

Verification
REQ-031 A read addr 2 alone, memory preloaded 0x0080 -> a_gnt same cycle, a_rvalid next cycle, a_rdata = 0x0080.
REQ-032 A and B both request in first cycle after reset -> A granted, then B next cycle; alternate A,B,A,B under continuous conflict.
REQ-033 B writes 0xBEEF to addr 5, A reads addr 5 next cycle -> a_rdata = 0xBEEF.
REQ-034 ARB_LOCK_EN, b_lock = 1 held, A requesting continuously -> 4 consecutive B grants, then A granted.
REQ-035 Rst asserted in the cycle after a granted read -> rvalid stays 0, all gnt 0; first post-reset conflict grants A.
REQ-036 Random req/we traffic, 1000 cycles -> never two gnts, no starvation beyond 1 cycle (LOCK_MAX cycles with lock), memory matches reference model.
